alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/minisys_alu_pkg.sv | 58 +++++
 rtl/alu_ctrl_decode.sv | 54 +++++
 rtl/alu_issue.sv | 72 +++++++
 3 files changed

// File: rtl/minisys_alu_pkg.sv
// minisys_alu_pkg: ALU control codes, MIPS opcode/funct constants and the issue payload type
package minisys_alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_LUI  = 4'b0101;
  localparam logic [3:0] ALU_ADDU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic        illegal;
  } payload_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational MIPS decode of instr/rs_data/rt_data into an ALU payload
module alu_ctrl_decode
  import minisys_alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output payload_t    payload
);
  logic [31:0] a, b, sx, zx;
  logic [3:0] ctl;
  logic ok;
  always_comb begin
    sx = {{16{instr[15]}}, instr[15:0]};
    zx = {16'h0, instr[15:0]};
    a = rs_data;
    b = rt_data;
    ctl = ALU_AND;
    ok = 1'b1;
    case (instr[31:26])
      OP_RTYPE: case (instr[5:0])
        FN_SLL:  begin a = {27'h0, instr[10:6]}; ctl = ALU_SLL; end
        FN_SRL:  begin a = {27'h0, instr[10:6]}; ctl = ALU_SRL; end
        FN_SRA:  begin a = {27'h0, instr[10:6]}; ctl = ALU_SRA; end
        FN_SLLV: ctl = ALU_SLL;
        FN_SRLV: ctl = ALU_SRL;
        FN_SRAV: ctl = ALU_SRA;
        FN_ADD:  ctl = ALU_ADD;
        FN_ADDU: ctl = ALU_ADDU;
        FN_SUB:  ctl = ALU_SUB;
        FN_SUBU: ctl = ALU_SUBU;
        FN_AND:  ctl = ALU_AND;
        FN_OR:   ctl = ALU_OR;
        FN_XOR:  ctl = ALU_XOR;
        FN_NOR:  ctl = ALU_NOR;
        FN_SLT:  ctl = ALU_SLT;
        FN_SLTU: ctl = ALU_SLTU;
        default: ok = 1'b0;
      endcase
      OP_BEQ, OP_BNE: ctl = ALU_SUBU;
      OP_ADDI:  begin b = sx; ctl = ALU_ADD;  end
      OP_ADDIU: begin b = sx; ctl = ALU_ADDU; end
      OP_SLTI:  begin b = sx; ctl = ALU_SLT;  end
      OP_SLTIU: begin b = sx; ctl = ALU_SLTU; end
      OP_ANDI:  begin b = zx; ctl = ALU_AND;  end
      OP_ORI:   begin b = zx; ctl = ALU_OR;   end
      OP_XORI:  begin b = zx; ctl = ALU_XOR;  end
      OP_LUI:   begin b = zx; ctl = ALU_LUI;  end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin b = sx; ctl = ALU_ADDU; end
      default: ok = 1'b0;
    endcase
    payload = ok ? payload_t'{a, b, ctl, 1'b0} : payload_t'{32'h0, 32'h0, ALU_AND, 1'b1};
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode-to-EX issue register with valid/ready handshake; two-entry skid buffer when ALU_ISSUE_SKID_EN is defined
module alu_issue
  import minisys_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  output logic        illegal
);
  payload_t dec, out_q, out_d;
  logic out_valid_q, out_valid_d, acc, out_load;
  alu_ctrl_decode u_dec (
    .instr(instr),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .payload(dec)
  );
  assign out_load = !out_valid_q || out_ready;
  assign acc = in_valid && in_ready;
`ifdef ALU_ISSUE_SKID_EN
  payload_t skid_q, skid_d;
  logic skid_valid_q, skid_valid_d, in_ready_q;
  assign in_ready = in_ready_q && !rst && !flush;
  always_comb begin
    out_valid_d = flush ? 1'b0 : out_load ? (skid_valid_q || acc) : 1'b1;
    out_d = !out_load ? out_q : skid_valid_q ? skid_q : acc ? dec : out_q;
    skid_valid_d = !flush && (out_load ? (skid_valid_q && acc) : (skid_valid_q || acc));
    skid_d = acc ? dec : skid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q <= skid_d;
      in_ready_q <= !skid_valid_d;
    end
  end
`else
  assign in_ready = !rst && !flush && out_load;
  always_comb begin
    out_valid_d = !flush && (acc || (out_valid_q && !out_ready));
    out_d = acc ? dec : out_q;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q <= out_d;
    end
  end
  assign out_valid = out_valid_q;
  assign alu_a = out_q.alu_a;
  assign alu_b = out_q.alu_b;
  assign alu_control = out_q.alu_control;
  assign illegal = out_q.illegal;
endmodule
